// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and types for the alu execution controller.
// Opcode/funct encodings of the supported MIPS subset, FSM state type and
// the idle instruction word presented to the alu.
package alu_ctrl_pkg;

    // addu $0,$0,$0: harmless word driven on the alu whenever nothing executes
    localparam logic [31:0] ALU_NOP = 32'h0000_0021;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational pre-screen of an instruction word.
// Flags whether the alu supports it, where its result goes, whether the
// writeback comes from the less-than flag, and whether overflow traps.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic       legal,
    output logic       has_dest,
    output logic [4:0] dest_addr,
    output logic       is_slt,
    output logic       ovf_traps
);

    // Classify the instruction; anything not listed stays illegal.
    always_comb begin
        legal     = 1'b0;
        has_dest  = 1'b0;
        dest_addr = 5'd0;
        is_slt    = 1'b0;
        ovf_traps = 1'b0;
        case (op)
            OP_RTYPE: begin
                dest_addr = rd;
                case (funct)
                    FN_ADD, FN_SUB: begin
                        legal     = 1'b1;
                        has_dest  = 1'b1;
                        ovf_traps = 1'b1;
                    end
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        legal    = 1'b1;
                        has_dest = 1'b1;
                    end
                    FN_SLT: begin
                        legal    = 1'b1;
                        has_dest = 1'b1;
                        is_slt   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                legal     = 1'b1;
                has_dest  = 1'b1;
                dest_addr = rt;
                ovf_traps = 1'b1;
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                legal     = 1'b1;
                has_dest  = 1'b1;
                dest_addr = rt;
            end
            OP_BEQ, OP_BNE: begin
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequencing controller around the combinational alu.
// Owns the two-entry register file, screens instructions, runs one alu
// cycle, writes back and returns a response over a valid/ready handshake.
// Define ALU_CTRL_PERF_EN to add the perf_retired / perf_ovf counters.
//
// state | meaning
// IDLE  | waiting for an instruction; register-file preload accepted
// EXEC  | latched instruction on the alu; capture flags, write back
// RESP  | response held on res_* until res_ready
module alu_exec_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = ALU_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        init_we,
    input  logic        init_addr,
    input  logic [31:0] init_data,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_flags,
    output logic        res_wrote,
    output logic        res_illegal
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0] perf_retired,
    output logic [15:0] perf_ovf
`endif
);

    ctrl_state_e state_q, state_d;

    logic [31:0] instr_q;
    logic        dest_ok_q;
    logic        dest_sel_q;
    logic        is_slt_q;
    logic        ovf_traps_q;
    logic [31:0] reg0_q, reg1_q;

    logic        dec_legal, dec_has_dest, dec_is_slt, dec_ovf_traps;
    logic [4:0]  dec_dest;

    logic        accept;
    logic        ovf_hit;
    logic        wb_en;
    logic [31:0] wb_value;

    alu_ctrl_decode u_decode (
        .op        (instr[31:26]),
        .funct     (instr[5:0]),
        .rt        (instr[20:16]),
        .rd        (instr[15:11]),
        .legal     (dec_legal),
        .has_dest  (dec_has_dest),
        .dest_addr (dec_dest),
        .is_slt    (dec_is_slt),
        .ovf_traps (dec_ovf_traps)
    );

    assign accept   = (state_q == IDLE) && instr_valid && !init_we;
    assign wb_value = is_slt_q ? {31'b0, alu_flags[1]} : alu_result;
    // Overflow on a trapping op cancels the writeback, as a MIPS trap would.
    assign ovf_hit  = ovf_traps_q && alu_flags[2];
    assign wb_en    = (state_q == EXEC) && dest_ok_q && !ovf_hit;

    assign alu_regA = reg0_q;
    assign alu_regB = reg1_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and handshake / alu-drive outputs.
    always_comb begin
        state_d         = state_q;
        instr_ready     = 1'b0;
        res_valid       = 1'b0;
        alu_instruction = NOP_INSTR;
        case (state_q)
            IDLE: begin
                instr_ready = !init_we;
                if (instr_valid && !init_we) state_d = dec_legal ? EXEC : RESP;
            end
            EXEC: begin
                alu_instruction = instr_q;
                state_d         = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the accepted instruction and the decode facts EXEC needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= NOP_INSTR;
            dest_ok_q   <= 1'b0;
            dest_sel_q  <= 1'b0;
            is_slt_q    <= 1'b0;
            ovf_traps_q <= 1'b0;
        end else if (accept) begin
            instr_q     <= instr;
            dest_ok_q   <= dec_has_dest && (dec_dest[4:1] == 4'd0);
            dest_sel_q  <= dec_dest[0];
            is_slt_q    <= dec_is_slt;
            ovf_traps_q <= dec_ovf_traps;
        end
    end

    // Register file: preload only while idle, writeback at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg0_q <= 32'd0;
            reg1_q <= 32'd0;
        end else if ((state_q == IDLE) && init_we) begin
            if (init_addr) reg1_q <= init_data;
            else           reg0_q <= init_data;
        end else if (wb_en) begin
            if (dest_sel_q) reg1_q <= wb_value;
            else            reg0_q <= wb_value;
        end
    end

    // Response capture: illegal on accept, alu outcome at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data    <= 32'd0;
            res_flags   <= 3'd0;
            res_wrote   <= 1'b0;
            res_illegal <= 1'b0;
        end else if (accept && !dec_legal) begin
            res_data    <= 32'd0;
            res_flags   <= 3'd0;
            res_wrote   <= 1'b0;
            res_illegal <= 1'b1;
        end else if (state_q == EXEC) begin
            res_data    <= wb_value;
            res_flags   <= alu_flags;
            res_wrote   <= wb_en;
            res_illegal <= 1'b0;
        end
    end

`ifdef ALU_CTRL_PERF_EN
    // Retired-instruction and suppressed-overflow counters, free-wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= 16'd0;
            perf_ovf     <= 16'd0;
        end else begin
            if ((state_q == RESP) && res_ready) perf_retired <= perf_retired + 16'd1;
            if ((state_q == EXEC) && dest_ok_q && ovf_hit) perf_ovf <= perf_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: self-checking bench for alu_exec_ctrl.
// Contains a behavioural alu stub (drives alu_result/alu_flags from the
// controller's alu outputs), a table of directed vectors, hand-written
// multi-cycle sequences and a randomized phase checked against a model.
module tb_alu_exec_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0021;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic        init_we = 1'b0;
    logic        init_addr = 1'b0;
    logic [31:0] init_data = 32'd0;
    logic [31:0] alu_instruction, alu_regA, alu_regB;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [2:0]  res_flags;
    logic        res_wrote, res_illegal;
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] perf_retired, perf_ovf;
`endif

    int total = 0;
    int bad = 0;
    int n_retired = 0;
    int n_ovf = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .init_we         (init_we),
        .init_addr       (init_addr),
        .init_data       (init_data),
        .alu_instruction (alu_instruction),
        .alu_regA        (alu_regA),
        .alu_regB        (alu_regB),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_flags       (res_flags),
        .res_wrote       (res_wrote),
        .res_illegal     (res_illegal)
`ifdef ALU_CTRL_PERF_EN
        ,
        .perf_retired    (perf_retired),
        .perf_ovf        (perf_ovf)
`endif
    );

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  flags;
    } alu_out_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  flags;
        logic        wrote;
        logic        illegal;
        logic        supp;
        logic [31:0] r0;
        logic [31:0] r1;
    } exp_t;

    typedef struct {
        logic [31:0] r0, r1, ins;
        int          hold;
        logic [31:0] data;
        logic [2:0]  flags;
        logic        wrote, illegal, supp;
        logic [31:0] er0, er1;
    } vec_t;

    // Alu stub. It reports signed overflow on unsigned add/sub too, so the
    // controller's choice of which ops trap is actually observable.
    function automatic alu_out_t alu_eval(input logic [31:0] ins, input logic [31:0] ra, input logic [31:0] rb);
        alu_out_t o;
        logic [31:0] a, b, r, simm, zimm;
        logic ov, lt, isbr, br;
        a    = (ins[25:21] == 5'd0) ? ra : (ins[25:21] == 5'd1) ? rb : 32'd0;
        b    = (ins[20:16] == 5'd0) ? ra : (ins[20:16] == 5'd1) ? rb : 32'd0;
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'd0, ins[15:0]};
        r = 32'd0; ov = 1'b0; lt = 1'b0; isbr = 1'b0; br = 1'b0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
                6'h22, 6'h23: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: begin lt = $signed(a) < $signed(b); r = {31'd0, lt}; end
                default: r = 32'd0;
            endcase
            6'h08, 6'h09: begin r = a + simm; ov = (a[31] == simm[31]) && (r[31] != a[31]); end
            6'h0C: r = a & zimm;
            6'h0D: r = a | zimm;
            6'h0E: r = a ^ zimm;
            6'h04: begin r = a - b; isbr = 1'b1; br = (a == b); end
            6'h05: begin r = a - b; isbr = 1'b1; br = (a != b); end
            default: r = 32'd0;
        endcase
        o.result = r;
        o.flags  = {ov, lt, isbr ? br : (r == 32'd0)};
        return o;
    endfunction

    alu_out_t alu_o;
    // Alu stub wired to the controller's alu interface.
    always_comb alu_o = alu_eval(alu_instruction, alu_regA, alu_regB);
    assign alu_result = alu_o.result;
    assign alu_flags  = alu_o.flags;

    // Reference: what one instruction should do given the register contents.
    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] r0, input logic [31:0] r1);
        exp_t e;
        alu_out_t a;
        logic [5:0] op, fn;
        logic legal, trap, dest_ok;
        logic [4:0] dest;
        op = ins[31:26];
        fn = ins[5:0];
        a  = alu_eval(ins, r0, r1);
        e  = '0;
        e.r0 = r0;
        e.r1 = r1;
        if (op == 6'h00) legal = fn inside {[6'h20:6'h27], 6'h2A};
        else             legal = op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05};
        if (!legal) begin
            e.illegal = 1'b1;
            return e;
        end
        e.flags = a.flags;
        e.data  = (op == 6'h00 && fn == 6'h2A) ? {31'd0, a.flags[1]} : a.result;
        dest    = (op == 6'h00) ? ins[15:11] : ins[20:16];
        dest_ok = !(op == 6'h04 || op == 6'h05) && (dest < 5'd2);
        trap    = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08;
        if (dest_ok) begin
            if (trap && a.flags[2]) e.supp = 1'b1;
            else begin
                e.wrote = 1'b1;
                if (dest == 5'd0) e.r0 = e.data;
                else              e.r1 = e.data;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic a, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(posedge clk);
        #1 init_we = 1'b0;
    endtask

    task automatic check_resp(input string tag, input exp_t e);
        check({tag, " res_valid"},   res_valid,   1);
        check({tag, " instr_ready"}, instr_ready, 0);
        check({tag, " res_data"},    res_data,    e.data);
        check({tag, " res_flags"},   res_flags,   e.flags);
        check({tag, " res_wrote"},   res_wrote,   e.wrote);
        check({tag, " res_illegal"}, res_illegal, e.illegal);
    endtask

    // Offer one instruction, follow it through EXEC/RESP, hold the response
    // for 'hold' extra cycles (poking init_we meanwhile), then hand it off.
    task automatic run_instr(input string tag, input logic [31:0] ins, input int hold, input exp_t e);
        int k, nonnop;
        logic got;
        logic [31:0] exec_word;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        k = 0;
        while (!instr_ready && k < 20) begin @(negedge clk); k++; end
        check({tag, " accept_wait"}, k, 0);
        @(posedge clk);
        #1 instr_valid = 1'b0; instr = $urandom();
        nonnop = 0; got = 1'b0; k = 0; exec_word = NOP;
        while (!got && k < 10) begin
            @(negedge clk); k++;
            if (alu_instruction !== NOP) begin nonnop++; exec_word = alu_instruction; end
            if (res_valid) got = 1'b1;
        end
        check({tag, " latency"},     k,         e.illegal ? 1 : 2);
        check({tag, " exec_cycles"}, nonnop,    e.illegal ? 0 : 1);
        check({tag, " exec_word"},   exec_word, e.illegal ? NOP : ins);
        check_resp(tag, e);
        check({tag, " regA"}, alu_regA, e.r0);
        check({tag, " regB"}, alu_regB, e.r1);
        for (int h = 0; h < hold; h++) begin
            init_we = 1'b1; init_addr = h[0]; init_data = $urandom();
            @(negedge clk);
            check_resp({tag, " hold"}, e);
        end
        init_we = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        n_retired++;
        if (e.supp) n_ovf++;
        check({tag, " valid_drop"},  res_valid,   0);
        check({tag, " ready_back"},  instr_ready, 1);
        check({tag, " regA_after"},  alu_regA,    e.r0);
        check({tag, " regB_after"},  alu_regB,    e.r1);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd0;
            3: return 32'd1;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [5:0] rfn [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h03};
        logic [5:0] iop [7]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05};
        logic [5:0] bop [6]  = '{6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h02, 6'h0F};
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int kind;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        imm = ($urandom_range(0, 1) == 0) ? 16'($urandom()) : 16'h8000 - 16'($urandom_range(0, 1));
        kind = $urandom_range(0, 9);
        if (kind < 5)      return {6'h00, rs, rt, rd, 5'($urandom()), rfn[$urandom_range(0, 11)]};
        else if (kind < 8) return {iop[$urandom_range(0, 6)], rs, rt, imm};
        else               return {bop[$urandom_range(0, 5)], rs, rt, imm};
    endfunction

    vec_t vecs[14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] m_r0, m_r1;

        //            r0            r1            instr         hold data          flg     w     ill   sup   er0           er1
        vecs[0]  = '{32'h7FFF_FFFF, 32'd1,        32'h0001_0020, 0, 32'h8000_0000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1};
        vecs[1]  = '{32'd5,         32'd0,        32'h2001_FFFF, 1, 32'd4,         3'b000, 1'b1, 1'b0, 1'b0, 32'd5,         32'd4};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd1,        32'h0001_002A, 0, 32'd1,         3'b010, 1'b1, 1'b0, 1'b0, 32'd1,         32'd1};
        vecs[3]  = '{32'd9,         32'd9,        32'h1001_0000, 0, 32'd0,         3'b001, 1'b0, 1'b0, 1'b0, 32'd9,         32'd9};
        vecs[4]  = '{32'd9,         32'd9,        32'h1401_0000, 0, 32'd0,         3'b000, 1'b0, 1'b0, 1'b0, 32'd9,         32'd9};
        vecs[5]  = '{32'd3,         32'd4,        32'h8C01_0000, 4, 32'd0,         3'b000, 1'b0, 1'b1, 1'b0, 32'd3,         32'd4};
        vecs[6]  = '{32'h7FFF_FFFF, 32'd1,        32'h0001_0021, 0, 32'h8000_0000, 3'b100, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd1};
        vecs[7]  = '{32'h8000_0000, 32'd1,        32'h0001_0822, 4, 32'h7FFF_FFFF, 3'b100, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd1};
        vecs[8]  = '{32'h0000_00F0, 32'h0000_000F, 32'h0001_1025, 0, 32'h0000_00FF, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F};
        vecs[9]  = '{32'd7,         32'd8,        32'h0001_002B, 0, 32'd0,         3'b000, 1'b0, 1'b1, 1'b0, 32'd7,         32'd8};
        vecs[10] = '{32'd0,         32'h0000_1234, 32'h3020_00FF, 0, 32'h0000_0034, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0034, 32'h0000_1234};
        vecs[11] = '{32'd0,         32'd0,        32'h0001_0027, 2, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{32'h0000_8000, 32'd5,        32'h3801_8000, 0, 32'd0,         3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_8000, 32'd0};
        vecs[13] = '{32'd0,         32'd1,        32'h0001_0823, 0, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0,         32'hFFFF_FFFF};

        // Reset state.
        #12;
        check("rst res_valid",   res_valid,       0);
        check("rst instr_ready", instr_ready,     1);
        check("rst alu_instr",   alu_instruction, NOP);
        check("rst regA",        alu_regA,        0);
        check("rst regB",        alu_regB,        0);
        check("rst res_data",    res_data,        0);
        check("rst res_flags",   res_flags,       0);
        check("rst res_wrote",   res_wrote,       0);
        check("rst res_illegal", res_illegal,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            preload(1'b0, vecs[i].r0);
            preload(1'b1, vecs[i].r1);
            e = '{vecs[i].data, vecs[i].flags, vecs[i].wrote, vecs[i].illegal,
                  vecs[i].supp, vecs[i].er0, vecs[i].er1};
            run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].hold, e);
        end

        // Preload strobe blocks acceptance in the same cycle.
        @(negedge clk);
        init_we = 1'b1; init_addr = 1'b0; init_data = 32'h0000_ABCD;
        instr = 32'h8C01_0000; instr_valid = 1'b1;
        #1 check("collide instr_ready", instr_ready, 0);
        @(posedge clk);
        #1 init_we = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        check("collide no_resp", res_valid, 0);
        check("collide regA",    alu_regA,  32'h0000_ABCD);

        // Randomized phase against the reference model; state carries over.
        m_r0 = alu_regA;
        m_r1 = alu_regB;
        m_r0 = 32'h0000_ABCD;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ins;
            if ($urandom_range(0, 1) == 0) begin
                m_r0 = pick_val(); preload(1'b0, m_r0);
                m_r1 = pick_val(); preload(1'b1, m_r1);
            end
            ins = gen_instr();
            e = predict(ins, m_r0, m_r1);
            run_instr($sformatf("rnd%0d %h", i, ins), ins, $urandom_range(0, 2), e);
            m_r0 = e.r0;
            m_r1 = e.r1;
        end

`ifdef ALU_CTRL_PERF_EN
        check("perf_retired", {16'd0, perf_retired}, n_retired);
        check("perf_ovf",     {16'd0, perf_ovf},     n_ovf);
`endif

        // Reset during EXEC discards the instruction.
        preload(1'b0, 32'h1111);
        preload(1'b1, 32'h2222);
        @(negedge clk);
        instr = 32'h0001_0021; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("rstexec in_exec", alu_instruction, 32'h0001_0021);
        rst_n = 1'b0;
        #1;
        check("rstexec res_valid", res_valid,       0);
        check("rstexec regA",      alu_regA,        0);
        check("rstexec regB",      alu_regB,        0);
        check("rstexec alu_instr", alu_instruction, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstexec no_resp",    res_valid,   0);
        check("rstexec ready",      instr_ready, 1);
        check("rstexec regA_after", alu_regA,    0);
        check("rstexec res_wrote",  res_wrote,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Sequencing controller wrapped around the combinational `alu`.
- Accepts MIPS instructions over a valid/ready handshake and owns the 2-entry register file (reg0 = regA, reg1 = regB).
- Pre-screens opcodes, drives the ALU for one cycle, captures result and flags, writes back to the register file, then returns a response over a second valid/ready handshake.
- Sits between the instruction source and the ALU; the ALU is never presented an unsupported instruction.

Parameters:
- NOP_INSTR, 32'h0000_0021, value driven on alu_instruction when not in EXEC (addu $0,$0,$0).

Ports:
- clk  in  1  Clock; all state updates on rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- instr_valid  in  1  Instruction offered.
- instr_ready  out  1  Controller can accept an instruction.
- instr  in  32  MIPS instruction word.
- init_we  in  1  Register-file preload strobe.
- init_addr  in  1  Preload target (0 = reg0, 1 = reg1).
- init_data  in  32  Preload value.
- alu_instruction  out  32  To alu.instruction.
- alu_regA  out  32  To alu.regA; equals reg0.
- alu_regB  out  32  To alu.regB; equals reg1.
- alu_result  in  32  From alu.result.
- alu_flags  in  3  From alu.flags: [0] zero/branch, [1] negative/less-than, [2] overflow.
- res_valid  out  1  Response available.
- res_ready  in  1  Consumer accepts the response.
- res_data  out  32  Value written back (or raw ALU result if not written).
- res_flags  out  3  Captured ALU flags.
- res_wrote  out  1  Register file was updated by this instruction.
- res_illegal  out  1  Instruction rejected; ALU not exercised.

Behaviour:
- **Reset** (async, rst_n low): state = IDLE; reg0 = reg1 = 0; res_data = 0; res_flags = 0; res_wrote = 0; res_illegal = 0; res_valid = 0; alu_instruction = NOP_INSTR. Reset mid-instruction discards the instruction; no writeback.
- **States:** IDLE, EXEC, RESP.
  - instr_ready = (state == IDLE) && !init_we.
- **IDLE:**
  - If init_we is high, write reg[init_addr] = init_data. Any instruction offered in the same cycle is not accepted.
  - On instr_valid && instr_ready, latch instr and decode:
    - Legal: go to EXEC.
    - Illegal: go straight to RESP with res_illegal = 1, res_data = 0, res_flags = 0, res_wrote = 0.
  - init_we outside IDLE is ignored.
- **Legal set** (op, funct):
  - R-type (op 0): add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A.
  - I-type: addi 08, addiu 09, andi 0C, ori 0D, xori 0E, beq 04, bne 05.
  - Everything else is illegal, including slti/sltiu/sltu, lw/sw and shifts.
  - rs/rt fields are not checked; the ALU maps non-0/1 addresses to 0.
- **EXEC** (exactly 1 cycle):
  - alu_instruction = latched instr.
  - At the end of the cycle, capture alu_flags into res_flags and compute the writeback value:
    - slt: {31'b0, alu_flags[1]}.
    - All others: alu_result.
  - Destination: R-type uses instr[15:11]; I-type arithmetic/logic uses instr[20:16]; beq/bne have no destination.
  - Write enable = has destination && dest ∈ {0, 1} && !(alu_flags[2] && op ∈ {add, addi, sub}).
    - Overflow suppresses writeback, matching MIPS trap semantics.
  - If write enable: write reg[dest] at the same edge and set res_wrote = 1.
  - res_data = the writeback value regardless of res_wrote.
  - Go to RESP.
- **Outside EXEC:** alu_instruction = NOP_INSTR.
- **RESP:**
  - res_valid = 1; res_* hold stable while res_ready is low.
  - On res_ready, go to IDLE; res_valid drops next cycle.
- **Latency and throughput:**
  - Accept edge N; register-file update at edge N+1; res_valid high from N+1 until the handshake.
  - Minimum 3 cycles per instruction.
- **Arithmetic:** all 32-bit, wrap-around. Immediate extension is done by the ALU; the controller never modifies operands.

Optional Feature:
- **ALU_CTRL_PERF_EN** defined: adds outputs `perf_retired[15:0]` and `perf_ovf[15:0]`.
  - perf_retired increments on each RESP handshake.
  - perf_ovf increments in EXEC when overflow suppresses a write.
  - Both counters wrap at 16'hFFFF→0 and are cleared by rst_n.
- **Undefined:** those ports and the counter logic do not exist.

Decomposition:
- **Package alu_ctrl_pkg:**
  - op/funct localparams for the legal set.
  - State enum {IDLE, EXEC, RESP}.
  - NOP constant.
- **Sub-module alu_ctrl_decode** (combinational): instr → legal, has_dest, dest_addr, is_slt, ovf_traps.

Test Plan:
- Preload reg0 = 32'h7FFF_FFFF, reg1 = 1; instr 32'h0001_0020 (add rd0) → res_data 32'h8000_0000, res_flags 3'b100, res_wrote 0, reg0 unchanged.
- reg0 = 5; instr 32'h2001_FFFF (addi rt1, imm −1) → res_data 4, res_wrote 1, alu_regB = 4 after the response.
- reg0 = 32'hFFFF_FFFF, reg1 = 1; instr 32'h0001_002A (slt rd0) → res_flags 3'b010, reg0 = 1.
- reg0 = reg1 = 9; instr 32'h1001_0000 (beq) → res_flags 3'b001, res_wrote 0; then 32'h1401_0000 (bne) → res_flags 3'b000.
- instr 32'h8C01_0000 (lw) → res_illegal 1 one cycle after acceptance, alu_instruction stays NOP_INSTR, registers unchanged.
- Hold res_ready low 4 cycles → res_* stable, instr_ready 0; assert rst_n low during EXEC → res_valid 0 and reg0 = reg1 = 0 immediately.
